// File: rtl/eviction_sequencer_pkg.sv
// eviction_sequencer_pkg: sequencer state encoding, default geometry and the log2 helper used to size set indices
package eviction_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, SELECT, WRITEBACK, FILL, UPDATE} state_t;
  localparam int WAYS_DEFAULT = 8;
  localparam int SETS_DEFAULT = 64;
  function automatic int log2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction
endpackage

// File: rtl/lowest_set_bit.sv
// lowest_set_bit: keeps only the lowest set bit of a way vector; an all-zero vector maps to way 0
module lowest_set_bit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] onehot
);
  assign onehot = |raw ? raw & (~raw + WIDTH'(1)) : WIDTH'(1);
endmodule

// File: rtl/eviction_sequencer.sv
// eviction_sequencer: per-set valid/dirty tracking, victim latch and writeback-then-fill sequencing.
// Define EVICT_STATS_EN to add event counters that are dumped through $display when report is high.
module eviction_sequencer
  import eviction_sequencer_pkg::*;
#(
  parameter int NUMBER_OF_WAYS = WAYS_DEFAULT,
  parameter int NUMBER_OF_SETS = SETS_DEFAULT,
  parameter int INDEX_BITS = log2(NUMBER_OF_SETS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      miss_req,
  input  logic [INDEX_BITS-1:0]     miss_index,
  input  logic                      miss_is_write,
  output logic                      busy,
  output logic                      miss_ack,
  output logic [NUMBER_OF_WAYS-1:0] filled_way,
  input  logic                      hit_valid,
  input  logic [INDEX_BITS-1:0]     hit_index,
  input  logic [NUMBER_OF_WAYS-1:0] hit_way,
  input  logic                      hit_is_write,
  output logic                      hit_ready,
  output logic [NUMBER_OF_WAYS-1:0] ways_in_use,
  input  logic [NUMBER_OF_WAYS-1:0] selected_way,
  output logic [NUMBER_OF_WAYS-1:0] current_access,
  output logic                      access_valid,
  output logic                      wb_req,
  output logic [INDEX_BITS-1:0]     wb_index,
  output logic [NUMBER_OF_WAYS-1:0] wb_way,
  input  logic                      wb_ready,
  output logic                      fill_req,
  output logic [INDEX_BITS-1:0]     fill_index,
  output logic [NUMBER_OF_WAYS-1:0] fill_way,
  input  logic                      fill_ready,
  input  logic                      report
);
  state_t state, next_state;
  logic [NUMBER_OF_WAYS-1:0] valid_bits [NUMBER_OF_SETS];
  logic [NUMBER_OF_WAYS-1:0] dirty_bits [NUMBER_OF_SETS];
  logic [INDEX_BITS-1:0] index;
  logic [NUMBER_OF_WAYS-1:0] victim, candidate;
  logic write, started, hit_accept, victim_dirty;
  lowest_set_bit #(.WIDTH(NUMBER_OF_WAYS)) sanitizer (.raw(selected_way), .onehot(candidate));
  assign victim_dirty = |(valid_bits[index] & dirty_bits[index] & candidate);
  assign busy = state != IDLE;
  assign miss_ack = state == UPDATE;
  assign filled_way = miss_ack ? victim : '0;
  assign wb_req = state == WRITEBACK;
  assign wb_index = index;
  assign wb_way = victim;
  assign fill_req = state == FILL;
  assign fill_index = index;
  assign fill_way = victim;
  // UPDATE owns the access port; a set under eviction must not be touched by hits
  assign hit_ready = started && !miss_ack && !(busy && hit_index == index);
  assign hit_accept = hit_valid && hit_ready;
  assign access_valid = miss_ack || hit_accept;
  assign current_access = miss_ack ? victim : hit_accept ? hit_way : '0;
  assign ways_in_use = busy ? valid_bits[index] : valid_bits[miss_index];
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      next_state = miss_req ? SELECT : IDLE;
      SELECT:    next_state = victim_dirty ? WRITEBACK : FILL;
      WRITEBACK: next_state = wb_ready ? FILL : WRITEBACK;
      FILL:      next_state = fill_ready ? UPDATE : FILL;
      default:   next_state = IDLE;
    endcase
  end
  always_ff @(posedge clock) state <= reset ? IDLE : next_state;
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NUMBER_OF_SETS; s++) begin
        valid_bits[s] <= '0;
        dirty_bits[s] <= '0;
      end
      index <= '0;
      write <= 1'b0;
      victim <= '0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (state == IDLE && miss_req) begin
        index <= miss_index;
        write <= miss_is_write;
      end
      if (state == SELECT) victim <= candidate;
      if (wb_req && wb_ready) dirty_bits[index] <= dirty_bits[index] & ~victim;
      if (miss_ack) begin
        valid_bits[index] <= valid_bits[index] | victim;
        dirty_bits[index] <= write ? dirty_bits[index] | victim : dirty_bits[index] & ~victim;
      end
      if (hit_accept && hit_is_write) dirty_bits[hit_index] <= dirty_bits[hit_index] | hit_way;
    end
  end
`ifdef EVICT_STATS_EN
  logic [31:0] cycles, misses, writebacks, clean_evictions, empty_fills;
  logic victim_valid;
  assign victim_valid = |(valid_bits[index] & candidate);
  always_ff @(posedge clock) begin
    if (reset) begin
      cycles <= '0;
      misses <= '0;
      writebacks <= '0;
      clean_evictions <= '0;
      empty_fills <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      misses <= misses + 32'(state == IDLE && miss_req);
      writebacks <= writebacks + 32'(wb_req && wb_ready);
      clean_evictions <= clean_evictions + 32'(state == SELECT && victim_valid && !victim_dirty);
      empty_fills <= empty_fills + 32'(state == SELECT && !victim_valid);
    end
    if (report) $display("eviction_sequencer stats: cycles=%0d misses=%0d writebacks=%0d clean_evictions=%0d empty_fills=%0d",
                         cycles, misses, writebacks, clean_evictions, empty_fills);
  end
`else
  logic unused_report;
  assign unused_report = report;
`endif
endmodule

// File: tb/tb_eviction_sequencer.sv
// tb_eviction_sequencer: directed and randomized misses/hits compared every cycle against a set-level reference model
module tb_eviction_sequencer;
  localparam int W = 8;
  localparam int S = 64;
  localparam int IB = 6;
  logic clock = 1'b0, reset = 1'b1, report = 1'b0;
  logic miss_req = 1'b0, miss_is_write = 1'b0;
  logic [IB-1:0] miss_index = '0, hit_index = '0;
  logic hit_valid = 1'b0, hit_is_write = 1'b0;
  logic [W-1:0] hit_way = '0, selected_way = '0;
  logic wb_ready = 1'b1, fill_ready = 1'b1;
  logic busy, miss_ack, hit_ready, access_valid, wb_req, fill_req;
  logic [W-1:0] filled_way, ways_in_use, current_access, wb_way, fill_way;
  logic [IB-1:0] wb_index, fill_index;
  always #5 clock = ~clock;
  eviction_sequencer dut (
    .clock(clock), .reset(reset), .miss_req(miss_req), .miss_index(miss_index),
    .miss_is_write(miss_is_write), .busy(busy), .miss_ack(miss_ack), .filled_way(filled_way),
    .hit_valid(hit_valid), .hit_index(hit_index), .hit_way(hit_way), .hit_is_write(hit_is_write),
    .hit_ready(hit_ready), .ways_in_use(ways_in_use), .selected_way(selected_way),
    .current_access(current_access), .access_valid(access_valid), .wb_req(wb_req),
    .wb_index(wb_index), .wb_way(wb_way), .wb_ready(wb_ready), .fill_req(fill_req),
    .fill_index(fill_index), .fill_way(fill_way), .fill_ready(fill_ready), .report(report)
  );
  int total = 0, bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  // reference: per-set line tables plus the phase of the miss in flight
  // (0 waiting, 1 choosing victim, 2 writing back, 3 filling, 4 reporting the fill)
  bit [W-1:0] m_valid [S];
  bit [W-1:0] m_dirty [S];
  int phase = 0;
  bit [IB-1:0] m_idx = '0;
  bit [W-1:0] m_vic = '0;
  bit m_wr = 0, started = 0, checking = 0, fresh_reset = 0, hacc = 0;
  function automatic bit [W-1:0] lowest(input logic [W-1:0] v);
    bit [W-1:0] r;
    r = '0;
    for (int i = W - 1; i >= 0; i--) if (v[i]) r = '0;
    for (int i = 0; i < W; i++) if (v[i] && r == '0) r[i] = 1'b1;
    if (r == '0) r[0] = 1'b1;
    return r;
  endfunction
  function automatic bit exp_hit_ready();
    return started && phase != 4 && !(phase != 0 && hit_index == m_idx);
  endfunction
  always @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < S; s++) begin
        m_valid[s] = '0;
        m_dirty[s] = '0;
      end
      phase = 0;
      started = 0;
      checking = 1;
      fresh_reset = 1;
    end else begin
      hacc = hit_valid && exp_hit_ready();
      fresh_reset = 0;
      if (phase == 0 && miss_req) begin
        m_idx = miss_index;
        m_wr = miss_is_write;
        phase = 1;
      end else if (phase == 1) begin
        m_vic = lowest(selected_way);
        phase = (m_valid[m_idx] & m_dirty[m_idx] & m_vic) != 0 ? 2 : 3;
      end else if (phase == 2 && wb_ready) begin
        m_dirty[m_idx] &= ~m_vic;
        phase = 3;
      end else if (phase == 3 && fill_ready) begin
        phase = 4;
      end else if (phase == 4) begin
        m_valid[m_idx] |= m_vic;
        m_dirty[m_idx] = m_wr ? (m_dirty[m_idx] | m_vic) : (m_dirty[m_idx] & ~m_vic);
        phase = 0;
      end
      if (hacc && hit_is_write) m_dirty[hit_index] |= hit_way;
      started = 1;
    end
  end
  always @(negedge clock) if (checking) begin
    check("busy", busy, phase != 0);
    check("miss_ack", miss_ack, phase == 4);
    check("wb_req", wb_req, phase == 2);
    check("fill_req", fill_req, phase == 3);
    check("hit_ready", hit_ready, exp_hit_ready());
    check("ways_in_use", ways_in_use, phase == 0 ? m_valid[miss_index] : m_valid[m_idx]);
    check("access_valid", access_valid, phase == 4 || (hit_valid && exp_hit_ready()));
    if (phase == 4) begin
      check("filled_way", filled_way, m_vic);
      check("current_access fill", current_access, m_vic);
    end else if (hit_valid && exp_hit_ready()) check("current_access hit", current_access, hit_way);
    if (phase == 2) begin
      check("wb_index", wb_index, m_idx);
      check("wb_way", wb_way, m_vic);
    end
    if (phase == 3) begin
      check("fill_index", fill_index, m_idx);
      check("fill_way", fill_way, m_vic);
    end
    if (fresh_reset) begin
      check("reset filled_way", filled_way, 0);
      check("reset current_access", current_access, 0);
      check("reset wb_way", wb_way, 0);
      check("reset fill_way", fill_way, 0);
      check("reset wb_index", wb_index, 0);
      check("reset fill_index", fill_index, 0);
    end
  end
  bit rand_hits = 0, rand_ready = 0;
  task automatic step();
    @(posedge clock);
    #1;
    if (rand_hits) begin
      hit_valid = 1'($urandom_range(0, 1));
      hit_index = IB'($urandom_range(0, 7));
      hit_way = 8'(1) << $urandom_range(0, 7);
      hit_is_write = 1'($urandom_range(0, 1));
    end
    if (rand_ready) begin
      wb_ready = $urandom_range(0, 2) != 0;
      fill_ready = $urandom_range(0, 2) != 0;
    end
  endtask
  task automatic finish_miss();
    bit seen;
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (miss_ack) seen = 1;
      step();
    end
    check("miss completes", seen, 1);
  endtask
  task automatic do_miss(input logic [IB-1:0] idx, input logic wr, input logic [W-1:0] sel);
    miss_index = idx;
    miss_is_write = wr;
    selected_way = sel;
    miss_req = 1'b1;
    step();
    miss_req = 1'b0;
    finish_miss();
  endtask
  task automatic probe(input string tag, input logic [IB-1:0] idx, input logic wr,
                       input logic [W-1:0] sel, input logic exp_wb, input logic [W-1:0] exp_way);
    miss_index = idx;
    miss_is_write = wr;
    selected_way = sel;
    miss_req = 1'b1;
    step();
    miss_req = 1'b0;
    step();
    check({tag, " wb_req"}, wb_req, exp_wb);
    check({tag, " fill_req"}, fill_req, !exp_wb);
    check({tag, " way"}, exp_wb ? wb_way : fill_way, exp_way);
    finish_miss();
  endtask
  initial begin
    repeat (3) step();
    check("in reset hit_ready", hit_ready, 0);
    check("in reset busy", busy, 0);
    check("in reset ways_in_use", ways_in_use, 0);
    reset = 1'b0;
    step();
    check("hit_ready after reset", hit_ready, 1);
    // clean miss into empty set 5
    miss_index = 5;
    miss_is_write = 1'b0;
    selected_way = 8'h01;
    miss_req = 1'b1;
    step();
    miss_req = 1'b0;
    check("clean select busy", busy, 1);
    step();
    check("clean fill_req cycle2", fill_req, 1);
    step();
    check("clean miss_ack cycle3", miss_ack, 1);
    check("clean filled_way", filled_way, 8'h01);
    step();
    check("set5 ways_in_use", ways_in_use, 8'h01);
    // fill set 2, dirty way 3 by a write hit, then evict it with a stalled writeback
    for (int w = 0; w < W; w++) do_miss(2, 1'b0, 8'(1) << w);
    check("set2 full", ways_in_use, 8'hff);
    hit_valid = 1'b1;
    hit_index = 2;
    hit_way = 8'h08;
    hit_is_write = 1'b1;
    step();
    hit_valid = 1'b0;
    hit_is_write = 1'b0;
    wb_ready = 1'b0;
    miss_index = 2;
    miss_is_write = 1'b1;
    selected_way = 8'h08;
    miss_req = 1'b1;
    step();
    miss_req = 1'b0;
    step();
    for (int n = 0; n < 10; n++) begin
      check("stall wb_req", wb_req, 1);
      check("stall wb_way", wb_way, 8'h08);
      check("stall wb_index", wb_index, 2);
      check("stall no fill_req", fill_req, 0);
      step();
    end
    wb_ready = 1'b1;
    step();
    check("after wb fill_req", fill_req, 1);
    check("after wb fill_way", fill_way, 8'h08);
    finish_miss();
    probe("way3 dirty again", 2, 1'b0, 8'h08, 1'b1, 8'h08);
    probe("way3 clean", 2, 1'b0, 8'h08, 1'b0, 8'h08);
    probe("sanitize 01100000", 20, 1'b0, 8'h60, 1'b0, 8'h20);
    probe("sanitize zero", 21, 1'b0, 8'h00, 1'b0, 8'h01);
    // hits while a fill on set 7 is pending
    fill_ready = 1'b0;
    miss_index = 7;
    miss_is_write = 1'b0;
    selected_way = 8'h04;
    miss_req = 1'b1;
    step();
    miss_req = 1'b0;
    step();
    hit_valid = 1'b1;
    hit_index = 7;
    hit_way = 8'h02;
    #1;
    check("busy set hit_ready", hit_ready, 0);
    hit_index = 9;
    hit_way = 8'h10;
    #1;
    check("other set hit_ready", hit_ready, 1);
    check("other set access_valid", access_valid, 1);
    check("other set current_access", current_access, 8'h10);
    fill_ready = 1'b1;
    step();
    check("update hit_ready", hit_ready, 0);
    check("update current_access", current_access, 8'h04);
    hit_valid = 1'b0;
    step();
    // reset in the middle of a writeback
    do_miss(11, 1'b1, 8'h01);
    wb_ready = 1'b0;
    miss_index = 11;
    miss_is_write = 1'b0;
    miss_req = 1'b1;
    step();
    miss_req = 1'b0;
    step();
    check("pre-reset wb_req", wb_req, 1);
    reset = 1'b1;
    step();
    check("mid reset wb_req", wb_req, 0);
    check("mid reset busy", busy, 0);
    for (int s = 0; s < S; s++) begin
      miss_index = IB'(s);
      #1;
      check("mid reset row", ways_in_use, 0);
    end
    reset = 1'b0;
    wb_ready = 1'b1;
    step();
    // randomized traffic
    rand_hits = 1;
    rand_ready = 1;
    repeat (300) begin
      logic [W-1:0] sel;
      sel = $urandom_range(0, 3) == 0 ? W'(0) : W'($urandom);
      do_miss(IB'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), sel);
    end
    rand_hits = 0;
    rand_ready = 0;
    hit_valid = 1'b0;
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
